// File: rtl/bp_resolve.sv
// Execute-side branch resolver: checks EXE outcomes against an in-order FIFO of
// fetch-time predictions, drives registered BHT updates and mispredict redirects.
module bp_resolve #(
  parameter int DEPTH    = 8,
  parameter int CNT_BITS = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [31:0]               push_pc,
  input  logic                      push_pred_taken,
  input  logic [31:0]               push_pred_target,
  input  logic                      res_valid,
  input  logic [31:0]               res_pc,
  input  logic                      res_taken,
  input  logic [31:0]               res_target,
  input  logic                      flush,
  output logic                      upd_write,
  output logic [31:0]               upd_pc,
  output logic [31:0]               upd_dest,
  output logic                      upd_taken,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_pc,
  output logic [CNT_BITS-1:0]       stat_branches,
  output logic [CNT_BITS-1:0]       stat_mispred,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]       PTR_ONE  = 1;
  localparam logic [AW:0]         OCC_ONE  = 1;
  localparam logic [AW:0]         OCC_FULL = DEPTH[AW:0];
  localparam logic [CNT_BITS-1:0] STAT_ONE = 1;

  // Push handshake: an entry transfers on a rising edge where push_valid and
  // push_ready are both high; push_ready depends only on stored occupancy.
  logic [31:0]       r_mem_pc  [DEPTH];
  logic              r_mem_pt  [DEPTH];
  logic [31:0]       r_mem_tgt [DEPTH];
  logic [AW-1:0]     r_head, r_tail;
  logic [AW:0]       r_count;
  logic              r_upd_write, r_upd_taken, r_redirect_valid;
  logic [31:0]       r_upd_pc, r_upd_dest, r_redirect_pc;
  logic [CNT_BITS-1:0] r_stat_branches, r_stat_mispred;

  logic        w_match, w_pred_taken, w_mispred, w_clear, w_push, w_pop;
  logic [31:0] w_pred_target, w_fallthrough, w_correct_pc;

  assign push_ready    = (r_count != OCC_FULL);
  assign w_match       = res_valid && (r_count != '0) && (r_mem_pc[r_head] == res_pc);
  assign w_pred_taken  = w_match ? r_mem_pt[r_head]  : 1'b0;
  assign w_pred_target = w_match ? r_mem_tgt[r_head] : 32'd0;
  assign w_fallthrough = res_pc + 32'd8;
  assign w_mispred     = res_valid && ((w_pred_taken != res_taken) ||
                                       (res_taken && (w_pred_target != res_target)));
  assign w_correct_pc  = res_taken ? res_target : w_fallthrough;
  // A mispredict or flush means anything fetched this cycle is wrong-path.
  assign w_clear       = flush || w_mispred;
  assign w_push        = push_valid && push_ready && !w_clear;
  assign w_pop         = w_match && !w_clear;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_tail]  <= push_pc;
      r_mem_pt[r_tail]  <= push_pred_taken;
      r_mem_tgt[r_tail] <= push_pred_target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_ONE;
      if (w_pop)  r_head <= r_head + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_upd_write      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_dest       <= '0;
      r_upd_taken      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_stat_branches  <= '0;
      r_stat_mispred   <= '0;
    end else begin
      r_upd_write      <= res_valid;
      // flush owns the front-end redirect when both arrive together
      r_redirect_valid <= w_mispred && !flush;
      if (res_valid) begin
        r_upd_pc        <= res_pc;
        r_upd_dest      <= res_target;
        r_upd_taken     <= res_taken;
        r_redirect_pc   <= w_correct_pc;
        r_stat_branches <= r_stat_branches + STAT_ONE;
      end
      if (w_mispred) r_stat_mispred <= r_stat_mispred + STAT_ONE;
    end
  end

  assign upd_write      = r_upd_write;
  assign upd_pc         = r_upd_pc;
  assign upd_dest       = r_upd_dest;
  assign upd_taken      = r_upd_taken;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign stat_branches  = r_stat_branches;
  assign stat_mispred   = r_stat_mispred;
  assign count          = r_count;
endmodule

// File: doc/bp_resolve.md
Name: bp_resolve

Overview:
- Execute-side resolver for the branch predictor; it is the writer of the BHT update interface.
- Keeps an in-order FIFO of predictions issued at fetch. When a branch executes, it compares the recorded prediction against the actual outcome.
- Outputs a registered BHT update (is_write/executed_branch_pc/dest_pc/is_taken) and a registered front-end redirect on mispredict.
- Maintains mispredict statistics; sits between the F1 predictor and the EXE branch unit.

Parameters:
DEPTH, 8, prediction FIFO entries (power of two, >=2)
CNT_BITS, 32, width of statistics counters (wrap on overflow)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
push_valid  in  1  fetch records a prediction this cycle
push_ready  out  1  FIFO can accept; equals (count != DEPTH)
push_pc  in  32  pc of predicted branch
push_pred_taken  in  1  predicted direction
push_pred_target  in  32  predicted target (ignored if not taken)
res_valid  in  1  a branch resolved in EXE this cycle
res_pc  in  32  pc of resolved branch
res_taken  in  1  actual direction
res_target  in  32  actual taken target
flush  in  1  pipeline flush (exception/eret); clears FIFO
upd_write  out  1  BHT update strobe (to is_write)
upd_pc  out  32  to executed_branch_pc
upd_dest  out  32  to dest_pc
upd_taken  out  1  to is_taken
redirect_valid  out  1  mispredict redirect strobe, one cycle
redirect_pc  out  32  correct next fetch pc
stat_branches  out  CNT_BITS  resolved branch count
stat_mispred  out  CNT_BITS  mispredict count
count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, resetn=0): FIFO pointers and count=0; upd_write=0, upd_pc=0, upd_dest=0, upd_taken=0, redirect_valid=0, redirect_pc=0, stats=0; push_ready=1 once count=0. Reset mid-operation discards all entries immediately.
- Storage: circular buffer of {pc, pred_taken, pred_target}. Head/tail pointers wrap modulo DEPTH. count tracks occupancy, range 0..DEPTH.
- Push: accepted when push_valid && push_ready. Pushing while full is ignored and no state changes. push_ready does not depend on a same-cycle pop.
- Resolve (res_valid=1), evaluated combinationally against the head entry:
  - match = (count!=0) && head.pc==res_pc.
  - If match: pred_taken=head.pred_taken, pred_target=head.pred_target, and head pops.
  - If not match: the branch is treated as unpredicted (pred_taken=0), and nothing pops.
  - fallthrough = res_pc+8, covering branch plus delay slot; 32-bit wrap.
  - mispredict = (pred_taken!=res_taken) || (res_taken && pred_target!=res_target).
  - correct_pc = res_taken ? res_target : fallthrough.
- Outputs, registered one cycle after res_valid:
  - upd_write=1, upd_pc=res_pc, upd_dest=res_target, upd_taken=res_taken.
  - redirect_valid=mispredict, redirect_pc=correct_pc.
  - In cycles without res_valid, upd_write=0 and redirect_valid=0; data outputs hold their last values.
- Stats:
  - stat_branches increments on every res_valid.
  - stat_mispred increments on every mispredict.
  - Both wrap at 2^CNT_BITS.
- Mispredict: the FIFO is cleared at that clock edge (count=0, head=tail). A same-cycle push is dropped, because it belongs to the wrong path.
- flush: clears the FIFO at the edge and drops a same-cycle push.
  - flush has priority over res_valid for the FIFO.
  - A res_valid in the same cycle still produces its upd_write and stat_branches increment.
  - redirect_valid is suppressed in that case, because flush owns the redirect.
- Simultaneous push+pop with no mispredict and no flush: count is unchanged and both pointers advance. When count==DEPTH, a push is still refused even if a pop occurs.
- No combinational path from res_* to any output.

Test Plan:
1. Reset, then push {pc=0x1000, taken=1, tgt=0x2000}, then resolve {0x1000, taken=1, tgt=0x2000}. Next cycle: upd_write=1, upd_pc=0x1000, upd_dest=0x2000, upd_taken=1, redirect_valid=0, count=0, stat_branches=1, stat_mispred=0.
2. Push 3 entries, then resolve the first with taken=0 while it was predicted taken. Next cycle: redirect_valid=1, redirect_pc=0x1008, count=0, stat_mispred=1.
3. Predicted taken to 0x2000, actual taken to 0x3000. Required: redirect_pc=0x3000, and upd_dest=0x3000 on the same cycle.
4. Push 8 entries. Required: push_ready=0 and a 9th push is ignored. Then do a push and a matching resolve in the same cycle: the push is dropped, count=7. Then 7 more push/pops across the wrap point: order is preserved and no spurious redirect occurs.
5. With an empty FIFO, resolve pc=0x4000, taken=1, tgt=0x5000. Required: treated as unpredicted, redirect_valid=1, redirect_pc=0x5000, upd_write=1.
6. Assert flush together with a mispredicting resolve and a push. Required: count=0, redirect_valid=0, upd_write=1, stat_branches incremented. Then drop resetn asynchronously mid-stream: all outputs return to 0 before the next clock edge.
